// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: rebuilds pixel coordinates from an active-low
// H_sync/V_sync pair, checks line/frame lengths and reports lock and sync errors.
module vga_sync_decoder #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       H_sync,
  input  logic       V_sync,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MAX_C   = 11'(2 * H_TOTAL);
  localparam logic [9:0]  V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END_C   = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0]  V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_MAX_C   = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state;
  logic        h_prev;
  logic        v_line;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;

  logic h_edge, frame_ev, line_err, frame_err, timeout;
  logic h_in, v_in;

  always_comb begin
    h_edge    = h_prev & ~H_sync;
    frame_ev  = h_edge & ~V_sync & v_line;
    line_err  = h_edge && (h_cnt != H_LAST_C);
    frame_err = (v_cnt != V_LAST_C);
    // Flag the step onto the saturation value so the timeout pulses only once.
    timeout   = !h_edge && (h_cnt == H_MAX_C - 11'd1);
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly as the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEARCH;
      h_prev      <= 1'b0;
      v_line      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      h_prev      <= H_sync;
      frame_start <= frame_ev;
      sync_err    <= 1'b0;

      if (h_edge) begin
        h_cnt  <= '0;
        v_line <= V_sync;
        if (frame_ev)
          v_cnt <= '0;
        else if (v_cnt != V_MAX_C)
          v_cnt <= v_cnt + 10'd1;
      end else if (h_cnt != H_MAX_C) begin
        h_cnt <= h_cnt + 11'd1;
      end

      // A line error outranks a frame error on the same edge: one pulse, back to SEARCH.
      case (state)
        SEARCH: begin
          if (frame_ev) state <= VERIFY;
        end
        VERIFY, LOCKED: begin
          if (line_err || timeout) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end else if (frame_ev) begin
            if (frame_err) begin
              state    <= VERIFY;
              locked   <= 1'b0;
              sync_err <= 1'b1;
            end else begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    h_in   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    v_in   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    active = locked && h_in && v_in;
    col    = '0;
    row    = '0;
    if (active) begin
      col = 10'(h_cnt - H_START_C);
      row = v_cnt - V_START_C;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken raster so whole frames
// fit in a short run; frame-level table plus hand-written corner sequences.
module tb_vga_sync_decoder;

  localparam int HS = 4, HB = 3, HA = 10, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5,  VT = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       H_sync = 1'b1;
  logic       V_sync = 1'b1;
  logic [9:0] col, row;
  logic       active, frame_start, locked, sync_err;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .H_sync(H_sync), .V_sync(V_sync),
    .col(col), .row(row), .active(active), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: event counters plus an independent raster-order model of active pixels.
  int fs_total = 0, err_total = 0, act_total = 0, raster_err = 0;
  int r_col = 0, r_row = 0;
  int first_col = -1, first_row = -1, first_h = -1, first_v = -1;
  int last_col = -1, last_row = -1;
  bit first_pending = 1'b0;

  always @(negedge clk) begin
    if (frame_start) begin
      fs_total++;
      r_col = 0;
      r_row = 0;
      first_pending = 1'b1;
    end
    if (sync_err) err_total++;
    if (active) begin
      act_total++;
      if (!locked || int'(col) != r_col || int'(row) != r_row) raster_err++;
      if (first_pending) begin
        first_col = int'(col);
        first_row = int'(row);
        first_h   = int'(dut.h_cnt);
        first_v   = int'(dut.v_cnt);
        first_pending = 1'b0;
      end
      last_col = int'(col);
      last_row = int'(row);
      r_col++;
      if (r_col == HA) begin
        r_col = 0;
        r_row++;
      end
    end
  end

  task automatic tick(input logic h, input logic v);
    @(posedge clk);
    #1;
    H_sync = h;
    V_sync = v;
  endtask

  task automatic drive_line(input int len, input bit vlow);
    for (int i = 0; i < len; i++) tick((i < HS) ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1);
  endtask

  task automatic drive_frame(input int nlines, input int bad_line, input int bad_len);
    for (int l = 0; l < nlines; l++) drive_line((l == bad_line) ? bad_len : HT, l < VS);
  endtask

  typedef struct {
    int   nlines;
    int   bad_line;
    int   bad_len;
    int   exp_fs;
    int   exp_err;
    int   exp_act;
    int   exp_last_row;
    logic exp_locked;
  } frame_vec_t;

  frame_vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fs0, err0, act0, rerr0;
    bit found;

    vecs[0] = '{12, -1, 0,  1, 0, 0,  0, 1'b0};  // first frame event: SEARCH -> VERIFY
    vecs[1] = '{12, -1, 0,  1, 0, 50, 4, 1'b1};  // good frame -> LOCKED
    vecs[2] = '{12, -1, 0,  1, 0, 50, 4, 1'b1};
    vecs[3] = '{12, 6,  19, 1, 1, 30, 2, 1'b0};  // short line drops lock mid-frame
    vecs[4] = '{12, -1, 0,  1, 0, 0,  0, 1'b0};
    vecs[5] = '{12, -1, 0,  1, 0, 50, 4, 1'b1};
    vecs[6] = '{11, -1, 0,  1, 0, 50, 4, 1'b1};  // short frame, caught at next frame event
    vecs[7] = '{12, -1, 0,  1, 1, 0,  0, 1'b0};
    vecs[8] = '{12, -1, 0,  1, 0, 50, 4, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_col", int'(col), 0);
    check("reset_row", int'(row), 0);
    check("reset_active", int'(active), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_sync_err", int'(sync_err), 0);
    rst = 1'b0;

    tick(1'b1, 1'b1);
    drive_line(HT, 1'b0);  // tail of a previous frame so v_line is seen high

    for (int k = 0; k < 9; k++) begin
      fs0 = fs_total; err0 = err_total; act0 = act_total; rerr0 = raster_err;
      drive_frame(vecs[k].nlines, vecs[k].bad_line, vecs[k].bad_len);
      check($sformatf("v%0d_frame_start", k), fs_total - fs0, vecs[k].exp_fs);
      check($sformatf("v%0d_sync_err", k), err_total - err0, vecs[k].exp_err);
      check($sformatf("v%0d_active_cycles", k), act_total - act0, vecs[k].exp_act);
      check($sformatf("v%0d_raster", k), raster_err - rerr0, 0);
      check($sformatf("v%0d_locked", k), int'(locked), int'(vecs[k].exp_locked));
      if (vecs[k].exp_act > 0) begin
        check($sformatf("v%0d_first_col", k), first_col, 0);
        check($sformatf("v%0d_first_row", k), first_row, 0);
        check($sformatf("v%0d_first_hcnt", k), first_h, HS + HB);
        check($sformatf("v%0d_first_vcnt", k), first_v, VS + VB);
        check($sformatf("v%0d_last_col", k), last_col, HA - 1);
        check($sformatf("v%0d_last_row", k), last_row, vecs[k].exp_last_row);
      end
    end

    // Timeout: H_sync stuck high while locked.
    err0 = err_total;
    for (int i = 0; i < HS; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 4 * HT && !found; i++) begin
      @(negedge clk);
      if (dut.h_cnt == 11'(2 * HT)) found = 1'b1;
    end
    check("timeout_reached", int'(found), 1);
    check("timeout_sync_err", int'(sync_err), 1);
    check("timeout_locked", int'(locked), 0);
    repeat (5) @(negedge clk);
    check("timeout_hcnt_hold", int'(dut.h_cnt), 2 * HT);
    check("timeout_err_pulses", err_total - err0, 1);
    check("timeout_state", int'(dut.state), 0);

    // Mid-frame reset with H_sync low.
    drive_line(HT, 1'b0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    for (int l = 0; l < 5; l++) drive_line(HT, l < VS);
    check("pre_reset_locked", int'(locked), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    H_sync = 1'b0;
    V_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_col", int'(col), 0);
    check("midrst_row", int'(row), 0);
    check("midrst_active", int'(active), 0);
    check("midrst_frame_start", int'(frame_start), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_sync_err", int'(sync_err), 0);
    check("midrst_hcnt", int'(dut.h_cnt), 0);
    check("midrst_vcnt", int'(dut.v_cnt), 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("no_edge_while_low", int'(dut.h_cnt), 30);
    H_sync = 1'b1;
    @(posedge clk);
    #1;
    check("no_edge_on_rise", int'(dut.h_cnt), 31);
    H_sync = 1'b0;
    @(posedge clk);
    #1;
    check("edge_after_high_low", int'(dut.h_cnt), 0);

    // V_sync falls mid-line: frame event waits for the next H edge.
    for (int i = 1; i < HT; i++) tick((i < HS) ? 1'b0 : 1'b1, 1'b1);
    fs0 = fs_total;
    for (int i = 0; i < HT; i++) tick((i < HS) ? 1'b0 : 1'b1, (i < 10) ? 1'b1 : 1'b0);
    check("vmid_no_early_fs", fs_total - fs0, 0);
    check("vmid_vcnt_before", int'(dut.v_cnt), 2);
    tick(1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("vmid_frame_start", int'(frame_start), 1);
    check("vmid_vcnt_zero", int'(dut.v_cnt), 0);
    check("vmid_hcnt_zero", int'(dut.h_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync generators. It samples the active-low H_sync/V_sync pair on the pixel clock and rebuilds the pixel coordinates (column, row, display-enable). It checks line and frame lengths against the nominal 640x480 timing and reports lock and sync errors. It sits in front of the frame-capture and self-check logic, so a generated or external sync stream can be verified and decoded on the same clock.

## Interface
Parameters:
- H_SYNC, 96, H_sync low width in clocks
- H_BP, 48, horizontal back porch in clocks
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, V_sync low width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- H_sync  in  1  horizontal sync, active low, synchronous to clk
- V_sync  in  1  vertical sync, active low, synchronous to clk
- col  out  10  active-pixel column 0..H_ACT-1; 0 when active=0
- row  out  10  active-pixel row 0..V_ACT-1; 0 when active=0
- active  out  1  display enable; only ever 1 while locked=1
- frame_start  out  1  one-cycle pulse at each recognised frame start
- locked  out  1  high while timing has been verified
- sync_err  out  1  one-cycle pulse on any timing violation

## Operation
- Input registers: h_prev and v_line hold the previous H_sync sample and the V_sync sample taken at the last H edge. Reset values are 0, so no edge is seen until the input has been sampled high.
- H edge: H_sync sampled 0 while h_prev=1. At that clock edge h_cnt loads 0.
- Otherwise h_cnt increments. It is 11 bits wide and saturates at 2*H_TOTAL.
- V_sync is sampled only at H edges.
- Frame event: an H edge where V_sync=0 and v_line=1. On a frame event v_cnt loads 0.
- At any other H edge v_cnt increments. It is 10 bits wide and saturates at 1023.
- Line check, at each H edge: error if h_cnt != H_TOTAL-1.
- Frame check, at each frame event: error if v_cnt != V_TOTAL-1.
- Timeout: error when h_cnt reaches 2*H_TOTAL.
- FSM, reset state SEARCH:
  - SEARCH: no checks. Frame event -> VERIFY.
  - VERIFY: line error or timeout -> SEARCH with sync_err. Frame event with a frame error -> VERIFY (restart) with sync_err. Frame event with a good frame -> LOCKED.
  - LOCKED: line error or timeout -> SEARCH with sync_err. Frame event with a frame error -> VERIFY with sync_err.
  - A line error and a frame error on the same edge produce a single sync_err pulse; the line error governs the next state (SEARCH).
- Decode: active = locked and H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACT.
  - col = h_cnt-(H_SYNC+H_BP) when active.
  - row = v_cnt-(V_SYNC+V_BP) when active.
- frame_start pulses on every frame event, whatever the state.

## Timing
- Reset: col=0, row=0, active=0, frame_start=0, locked=0, sync_err=0, h_cnt=0, v_cnt=0, state=SEARCH.
- Reset mid-frame aborts everything in 1 cycle. Relock requires a full verified frame after reset.
- Latency: h_cnt/v_cnt are registered, so h_cnt=0 in the cycle after H_sync is first sampled low. With defaults, active rises 144 cycles after that cycle.
- col/row/active are combinational decodes of the counters and state; no extra delay.
- frame_start, sync_err and locked are registered. frame_start and sync_err are high in the cycle after the offending or triggering edge.
- locked rises in the cycle after the second consecutive frame event, provided no error occurred between the two events.
- A V_sync fall mid-line is recognised at the next H edge.

## Test plan
1. Reset, then 3 ideal default frames -> locked=1 from the start of frame 2. First active cycle: col=0, row=0 at h_cnt=144, v_cnt=35. Last: col=639, row=479. Exactly 307200 active cycles per locked frame. frame_start pulses 3 times.
2. While locked, one line of 799 clocks -> one sync_err pulse and locked=0 at the following H edge. active stays 0. locked returns after the next frame event plus one good frame.
3. While locked, a frame of 524 lines -> sync_err at the frame event, state VERIFY. locked=1 again one frame later.
4. While locked, H_sync held high for 1600 clocks -> sync_err when h_cnt=1600, h_cnt holds at 1600, state SEARCH.
5. Assert rst for 3 cycles mid-frame with H_sync=0 -> all outputs 0. No H edge is seen until H_sync goes 1 then 0.
6. V_sync falls 100 clocks into a line -> the frame event, frame_start and v_cnt=0 occur at the next H edge, not earlier.
